ecc_60_rd_stage: RTL and testbench

Registered read-side stage directly downstream of the 60-bit SEC-DED decoder on the ECC-protected FIFO read path. Takes corrected data plus single/double-bit error flags and an entry address, and forwards them through a two-entry skid buffer with a valid/ready handshake. Keeps saturating error statistics, a sticky first-error log and an uncorrectable-error interrupt pulse for the CSR block.

---
 rtl/ecc_rd_pkg.sv | 38 +++
 rtl/ecc_sat_cnt.sv | 39 +++
 rtl/ecc_60_rd_stage.sv | 163 ++++++++++++++++
 tb/tb_ecc_60_rd_stage.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ecc_rd_pkg.sv
// Shared types for the ECC read-side stage: default widths, the entry record
// that travels through the skid buffer, and the occupancy state encoding.
package ecc_rd_pkg;

   localparam int ECC_DATA_WIDTH = 60;
   localparam int ECC_ADDR_WIDTH = 8;

   // One buffered word: data, address and flags always move together.
   typedef struct packed {
      logic [ECC_DATA_WIDTH-1:0] data;
      logic [ECC_ADDR_WIDTH-1:0] addr;
      logic                      sbit;
      logic                      dbit;
   } entry_t;

   // Skid buffer occupancy.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } occ_e;

   // Build an entry; both flags set is illegal and is treated as uncorrectable.
   function automatic entry_t make_entry(
      input logic [ECC_DATA_WIDTH-1:0] data,
      input logic [ECC_ADDR_WIDTH-1:0] addr,
      input logic                      sbit,
      input logic                      dbit
   );
      entry_t e;
      e.data = data;
      e.addr = addr;
      e.sbit = sbit & ~dbit;
      e.dbit = dbit;
      return e;
   endfunction

endpackage

// File: rtl/ecc_sat_cnt.sv
// Saturating event counter; clear has priority but a same-cycle increment
// still counts, so clear+inc leaves the counter at 1.
module ecc_sat_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_clr,
   input  logic         i_inc,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] r_cnt;
   logic [W-1:0] w_cnt_nxt;

   // Next count: clear/increment priority with hold at all-ones.
   always_comb begin
      w_cnt_nxt = r_cnt;
      if (i_clr) begin
         w_cnt_nxt = i_inc ? {{(W-1){1'b0}}, 1'b1} : {W{1'b0}};
      end else if (i_inc && (r_cnt != {W{1'b1}})) begin
         w_cnt_nxt = r_cnt + {{(W-1){1'b0}}, 1'b1};
      end else begin
         w_cnt_nxt = r_cnt;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= {W{1'b0}};
      end else begin
         r_cnt <= w_cnt_nxt;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/ecc_60_rd_stage.sv
// Read-side stage after the 60-bit SEC-DED decoder: two-entry skid buffer,
// saturating error counters, sticky first-error log and uncorrectable irq.
module ecc_60_rd_stage
   import ecc_rd_pkg::*;
#(
   parameter int DATA_WIDTH = ECC_DATA_WIDTH,
   parameter int ADDR_WIDTH = ECC_ADDR_WIDTH,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [ADDR_WIDTH-1:0] in_addr,
   input  logic                  in_sbit_err,
   input  logic                  in_dbit_err,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_sbit_err,
   output logic                  out_dbit_err,
   output logic [CNT_WIDTH-1:0]  sbe_cnt,
   output logic [CNT_WIDTH-1:0]  dbe_cnt,
   input  logic                  cnt_clr,
   output logic                  log_valid,
   output logic [ADDR_WIDTH-1:0] log_addr,
   output logic                  log_dbit,
   input  logic                  log_clr,
   output logic                  irq
);

   // The entry record is sized by the package; widths here must match it.
   occ_e   r_state, w_state_nxt;
   entry_t r_head, r_tail, w_head_nxt, w_tail_nxt, w_in_ent;
   logic   r_in_ready, r_out_valid, r_irq;
   logic   r_log_valid, r_log_dbit, w_log_valid_nxt, w_log_dbit_nxt;
   logic [ADDR_WIDTH-1:0] r_log_addr, w_log_addr_nxt;
   logic   w_accept, w_deliver, w_err;

   assign w_accept  = in_valid & r_in_ready;
   assign w_deliver = r_out_valid & out_ready;
   assign w_in_ent  = make_entry(in_data, in_addr, in_sbit_err, in_dbit_err);
   assign w_err     = w_in_ent.sbit | w_in_ent.dbit;

   // Skid buffer next state: head is the presented word, tail the overflow.
   always_comb begin
      w_state_nxt = r_state;
      w_head_nxt  = r_head;
      w_tail_nxt  = r_tail;
      case (r_state)
         ST_EMPTY: begin
            if (w_accept) begin
               w_head_nxt  = w_in_ent;
               w_state_nxt = ST_ONE;
            end else begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_ONE: begin
            if (w_accept && w_deliver) begin
               w_head_nxt = w_in_ent;
            end else if (w_accept) begin
               w_tail_nxt  = w_in_ent;
               w_state_nxt = ST_TWO;
            end else if (w_deliver) begin
               w_state_nxt = ST_EMPTY;
            end else begin
               w_state_nxt = ST_ONE;
            end
         end
         ST_TWO: begin
            if (w_deliver) begin
               w_head_nxt  = r_tail;
               w_state_nxt = ST_ONE;
            end else begin
               w_state_nxt = ST_TWO;
            end
         end
         default: begin
            w_state_nxt = ST_EMPTY;
         end
      endcase
   end

   // Buffer registers plus registered handshake outputs and irq pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_EMPTY;
         r_head      <= '0;
         r_tail      <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_irq       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_head      <= w_head_nxt;
         r_tail      <= w_tail_nxt;
         r_in_ready  <= (w_state_nxt != ST_TWO);
         r_out_valid <= (w_state_nxt != ST_EMPTY);
         r_irq       <= w_accept & w_in_ent.dbit;
      end
   end

   // Error log: first error loads, a dbit upgrades an sbit, clear yields to a new error.
   always_comb begin
      w_log_valid_nxt = r_log_valid;
      w_log_addr_nxt  = r_log_addr;
      w_log_dbit_nxt  = r_log_dbit;
      if (w_accept && w_err &&
          (log_clr || !r_log_valid || (!r_log_dbit && w_in_ent.dbit))) begin
         w_log_valid_nxt = 1'b1;
         w_log_addr_nxt  = w_in_ent.addr;
         w_log_dbit_nxt  = w_in_ent.dbit;
      end else if (log_clr) begin
         w_log_valid_nxt = 1'b0;
         w_log_addr_nxt  = {ADDR_WIDTH{1'b0}};
         w_log_dbit_nxt  = 1'b0;
      end else begin
         w_log_valid_nxt = r_log_valid;
      end
   end

   // Log registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_log_valid <= 1'b0;
         r_log_addr  <= {ADDR_WIDTH{1'b0}};
         r_log_dbit  <= 1'b0;
      end else begin
         r_log_valid <= w_log_valid_nxt;
         r_log_addr  <= w_log_addr_nxt;
         r_log_dbit  <= w_log_dbit_nxt;
      end
   end

   ecc_sat_cnt #(.W(CNT_WIDTH)) u_sbe_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (cnt_clr),
      .i_inc (w_accept & w_in_ent.sbit),
      .o_cnt (sbe_cnt)
   );

   ecc_sat_cnt #(.W(CNT_WIDTH)) u_dbe_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (cnt_clr),
      .i_inc (w_accept & w_in_ent.dbit),
      .o_cnt (dbe_cnt)
   );

   assign in_ready     = r_in_ready;
   assign out_valid    = r_out_valid;
   assign out_data     = r_head.data;
   assign out_sbit_err = r_head.sbit;
   assign out_dbit_err = r_head.dbit;
   assign log_valid    = r_log_valid;
   assign log_addr     = r_log_addr;
   assign log_dbit     = r_log_dbit;
   assign irq          = r_irq;

endmodule

// File: tb/tb_ecc_60_rd_stage.sv
// Directed self-checking bench for ecc_60_rd_stage.
module tb_ecc_60_rd_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_sbit_err, in_dbit_err;
   logic [59:0] in_data, out_data;
   logic [7:0]  in_addr, log_addr;
   logic        out_valid, out_ready, out_sbit_err, out_dbit_err;
   logic [15:0] sbe_cnt, dbe_cnt;
   logic        cnt_clr, log_valid, log_dbit, log_clr, irq;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   ecc_60_rd_stage dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_addr(in_addr),
      .in_sbit_err(in_sbit_err), .in_dbit_err(in_dbit_err),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_sbit_err(out_sbit_err), .out_dbit_err(out_dbit_err),
      .sbe_cnt(sbe_cnt), .dbe_cnt(dbe_cnt), .cnt_clr(cnt_clr),
      .log_valid(log_valid), .log_addr(log_addr), .log_dbit(log_dbit),
      .log_clr(log_clr), .irq(irq)
   );

   function automatic logic [59:0] dat(input logic [3:0] k);
      return {15{k}};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] k, input logic [7:0] a,
                        input logic s, input logic d);
      in_valid = v; in_data = dat(k); in_addr = a; in_sbit_err = s; in_dbit_err = d;
   endtask

   initial begin
      rst_n = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0; log_clr = 1'b0;
      drive(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
      #12;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_sbe", 64'(sbe_cnt), 64'd0);
      chk("rst_log_valid", 64'(log_valid), 64'd0);
      chk("rst_irq", 64'(irq), 64'd0);
      rst_n = 1'b1;
      tick();

      // Four back-to-back clean words, each visible one cycle after accept.
      for (int k = 1; k <= 4; k++) begin
         drive(1'b1, 4'(k), 8'(k), 1'b0, 1'b0);
         tick();
         chk("b2b_valid", 64'(out_valid), 64'd1);
         chk("b2b_data", 64'(out_data), 64'(dat(4'(k))));
      end
      drive(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
      tick();
      chk("b2b_drain", 64'(out_valid), 64'd0);
      chk("b2b_sbe", 64'(sbe_cnt), 64'd0);
      chk("b2b_dbe", 64'(dbe_cnt), 64'd0);
      chk("b2b_log", 64'(log_valid), 64'd0);

      // Backpressure: three stalled cycles hold exactly two words.
      out_ready = 1'b0;
      drive(1'b1, 4'hA, 8'h0A, 1'b0, 1'b0);
      tick();
      chk("bp1_data", 64'(out_data), 64'(dat(4'hA)));
      chk("bp1_ready", 64'(in_ready), 64'd1);
      drive(1'b1, 4'hB, 8'h0B, 1'b0, 1'b0);
      tick();
      chk("bp2_ready", 64'(in_ready), 64'd0);
      drive(1'b1, 4'hC, 8'h0C, 1'b0, 1'b0);
      tick();
      chk("bp3_ready", 64'(in_ready), 64'd0);
      chk("bp3_stable", 64'(out_data), 64'(dat(4'hA)));
      out_ready = 1'b1;
      tick();
      chk("rel1_data", 64'(out_data), 64'(dat(4'hB)));
      chk("rel1_ready", 64'(in_ready), 64'd1);
      tick();
      chk("rel2_data", 64'(out_data), 64'(dat(4'hC)));
      drive(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
      tick();
      chk("rel_drain", 64'(out_valid), 64'd0);

      // sbit then dbit: counters, log upgrade and one irq pulse.
      drive(1'b1, 4'h1, 8'h12, 1'b1, 1'b0);
      tick();
      chk("sb_flag", 64'(out_sbit_err), 64'd1);
      chk("sb_cnt", 64'(sbe_cnt), 64'd1);
      chk("sb_log_addr", 64'(log_addr), 64'h12);
      chk("sb_irq", 64'(irq), 64'd0);
      drive(1'b1, 4'h2, 8'h34, 1'b0, 1'b1);
      tick();
      chk("db_flag", 64'(out_dbit_err), 64'd1);
      chk("db_cnt", 64'(dbe_cnt), 64'd1);
      chk("db_sbe_cnt", 64'(sbe_cnt), 64'd1);
      chk("db_log_addr", 64'(log_addr), 64'h34);
      chk("db_log_dbit", 64'(log_dbit), 64'd1);
      chk("db_irq", 64'(irq), 64'd1);
      // Both flags: treated as dbit, log keeps the first dbit.
      drive(1'b1, 4'h3, 8'h56, 1'b1, 1'b1);
      tick();
      chk("both_sflag", 64'(out_sbit_err), 64'd0);
      chk("both_dflag", 64'(out_dbit_err), 64'd1);
      chk("both_sbe", 64'(sbe_cnt), 64'd1);
      chk("both_dbe", 64'(dbe_cnt), 64'd2);
      chk("both_log", 64'(log_addr), 64'h34);
      drive(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
      tick();
      chk("irq_pulse_end", 64'(irq), 64'd0);

      // Saturation of sbe_cnt and clear-with-increment.
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      chk("clr_sbe", 64'(sbe_cnt), 64'd0);
      chk("clr_dbe", 64'(dbe_cnt), 64'd0);
      drive(1'b1, 4'h5, 8'h77, 1'b1, 1'b0);
      repeat (65535) @(posedge clk);
      #1;
      chk("sat_reach", 64'(sbe_cnt), 64'hFFFF);
      tick();
      chk("sat_hold", 64'(sbe_cnt), 64'hFFFF);
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      chk("clr_inc", 64'(sbe_cnt), 64'd1);
      drive(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
      tick();

      // log_clr alongside an accepted sbit loads the new error.
      log_clr = 1'b1;
      drive(1'b1, 4'h6, 8'h05, 1'b1, 1'b0);
      tick();
      log_clr = 1'b0;
      drive(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
      chk("lclr_valid", 64'(log_valid), 64'd1);
      chk("lclr_addr", 64'(log_addr), 64'h05);
      chk("lclr_dbit", 64'(log_dbit), 64'd0);
      log_clr = 1'b1;
      tick();
      log_clr = 1'b0;
      chk("lclr_only", 64'(log_valid), 64'd0);

      // Reset with two words buffered.
      out_ready = 1'b0;
      drive(1'b1, 4'h8, 8'h08, 1'b1, 1'b0);
      tick();
      drive(1'b1, 4'h9, 8'h09, 1'b0, 1'b0);
      tick();
      chk("full_ready", 64'(in_ready), 64'd0);
      drive(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(out_valid), 64'd0);
      chk("arst_ready", 64'(in_ready), 64'd1);
      chk("arst_data", 64'(out_data), 64'd0);
      chk("arst_sbe", 64'(sbe_cnt), 64'd0);
      chk("arst_log", 64'(log_valid), 64'd0);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      drive(1'b1, 4'hE, 8'h0E, 1'b0, 1'b0);
      tick();
      chk("restart_valid", 64'(out_valid), 64'd1);
      chk("restart_data", 64'(out_data), 64'(dat(4'hE)));
      drive(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
      tick();
      chk("restart_drain", 64'(out_valid), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
